// File: rtl/pm_responder.sv
// Program-memory responder: boot-loaded instruction store answering sequencer fetches with 1-cycle latency.
// Optional feature: define PM_PARITY_EN to store and check an even-parity bit per word.
module pm_responder #(
  parameter int unsigned PM_DEPTH = 256,
  parameter int unsigned OPC_W    = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps_pm_cslt,
  input  logic             ps_pm_wrb,
  input  logic [15:0]      ps_pm_add,
  output logic [OPC_W-1:0] pm_ps_op,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [OPC_W-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_done,
  output logic [CNT_W-1:0] ld_cnt,
  output logic             pm_err,
  output logic             pm_perr
);

  localparam int unsigned AW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PM_DEPTH);
`ifdef PM_PARITY_EN
  localparam int unsigned MW = OPC_W + 1;
`else
  localparam int unsigned MW = OPC_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    mem_q [PM_DEPTH];
  logic [OPC_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             perr_q, perr_d;
  logic             wr_en;
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    rd_word;
  logic             par_bad;
  logic             in_range;

  assign rd_word  = mem_q[ps_pm_add[AW-1:0]];
  assign in_range = ({{(32-16){1'b0}}, ps_pm_add} < PM_DEPTH);

`ifdef PM_PARITY_EN
  // Stored bit makes the word's total popcount even, so any odd flip XORs to 1.
  assign wr_word = {^ld_data, ld_data};
  assign par_bad = ^rd_word;
`else
  assign wr_word = ld_data;
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    perr_d  = perr_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_d = '0;
        if (ld_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_LOAD: begin
        op_d = '0;
        if (ld_start) begin
          cnt_d  = '0;
          err_d  = 1'b0;
          perr_d = 1'b0;
        end else if (ld_valid && (cnt_q < DEPTH_C)) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (ld_last || (cnt_q == DEPTH_C - CNT_W'(1))) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ld_start) begin
          state_d = S_LOAD;
          op_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          perr_d  = 1'b0;
        end else if (ps_pm_cslt) begin
          if (ps_pm_wrb || !in_range) begin
            op_d  = '0;
            err_d = 1'b1;
          end else if (par_bad) begin
            op_d   = '0;
            perr_d = 1'b1;
          end else begin
            op_d = rd_word[OPC_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  // Array deliberately has no reset so contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[AW-1:0]] <= wr_word;
  end

  assign pm_ps_op = op_q;
  assign ld_ready = (state_q == S_LOAD);
  assign ld_done  = done_q;
  assign ld_cnt   = cnt_q;
  assign pm_err   = err_q;
  assign pm_perr  = perr_q;

endmodule

// File: tb/tb_pm_responder.sv
// Self-checking bench for pm_responder: directed sequence with randomized data against a word-level memory model.
module tb_pm_responder;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps_pm_cslt = 1'b0;
  logic        ps_pm_wrb = 1'b0;
  logic [15:0] ps_pm_add = '0;
  logic [31:0] pm_ps_op;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_done;
  logic [15:0] ld_cnt;
  logic        pm_err;
  logic        pm_perr;

  always #5 clk = ~clk;

  pm_responder #(.PM_DEPTH(DEPTH), .OPC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ps_pm_cslt(ps_pm_cslt), .ps_pm_wrb(ps_pm_wrb), .ps_pm_add(ps_pm_add),
    .pm_ps_op(pm_ps_op),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_cnt(ld_cnt),
    .pm_err(pm_err), .pm_perr(pm_perr)
  );

  // Reference model: what each address should hold, plus expected sticky/registered outputs.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] ref_op;
  logic        ref_err;
  int unsigned ref_cnt;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    ld_valid = $urandom_range(0, 1);
    ld_data  = $urandom();
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ref_cnt = 0;
    ref_err = 1'b0;
    ref_op  = '0;
    check("start_ready", 32'(ld_ready), 32'd1);
    check("start_cnt", 32'(ld_cnt), 32'd0);
    check("start_err", 32'(pm_err), 32'd0);
    check("start_op", pm_ps_op, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int unsigned gap;
    gap = $urandom_range(0, 2);
    for (int unsigned g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_data  = $urandom();
      tick();
      check("gap_cnt", 32'(ld_cnt), 32'(ref_cnt));
    end
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ref_mem[ref_cnt]   = data;
    ref_known[ref_cnt] = 1'b1;
    ref_cnt++;
    check("load_cnt", 32'(ld_cnt), 32'(ref_cnt));
    check("load_op_zero", pm_ps_op, 32'd0);
    if (last || ref_cnt == DEPTH) begin
      check("load_done", 32'(ld_done), 32'd1);
      check("load_ready_off", 32'(ld_ready), 32'd0);
    end else begin
      check("load_done_low", 32'(ld_done), 32'd0);
      check("load_ready_on", 32'(ld_ready), 32'd1);
    end
  endtask

  task automatic fetch(input logic [15:0] addr, input logic wr);
    ps_pm_cslt = 1'b1;
    ps_pm_wrb  = wr;
    ps_pm_add  = addr;
    tick();
    ps_pm_cslt = 1'b0;
    ps_pm_wrb  = 1'b0;
    if (wr || addr >= DEPTH) begin
      ref_op  = '0;
      ref_err = 1'b1;
    end else begin
      ref_op = ref_mem[addr];
    end
    check("fetch_op", pm_ps_op, ref_op);
    check("fetch_err", 32'(pm_err), 32'(ref_err));
  endtask

  initial begin
    logic [31:0] spec_words [4];
    int unsigned n;
    spec_words[0] = 32'h4000_0001;
    spec_words[1] = 32'h0C00_0005;
    spec_words[2] = 32'h0000_0000;
    spec_words[3] = 32'h0080_0000;
    for (int unsigned i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    ref_op = '0; ref_err = 1'b0; ref_cnt = 0;

    // Reset state
    tick(); tick();
    check("rst_op", pm_ps_op, 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_done", 32'(ld_done), 32'd0);
    check("rst_cnt", 32'(ld_cnt), 32'd0);
    check("rst_err", 32'(pm_err), 32'd0);
    check("rst_perr", 32'(pm_perr), 32'd0);
    rst = 1'b1;

    // Fetch in IDLE is not served
    ps_pm_cslt = 1'b1; ps_pm_add = 16'd0;
    tick();
    ps_pm_cslt = 1'b0;
    check("idle_op", pm_ps_op, 32'd0);
    check("idle_err", 32'(pm_err), 32'd0);

    // Directed 4-word load, then back-to-back fetches
    start_load();
    for (int unsigned i = 0; i < 4; i++) send_word(spec_words[i], i == 3);
    tick();
    check("done_pulse_end", 32'(ld_done), 32'd0);
    for (int unsigned i = 0; i < 4; i++) fetch(16'(i), 1'b0);

    // Idle sequencer: opcode holds
    ps_pm_add = 16'($urandom_range(0, 3));
    tick();
    check("hold_op", pm_ps_op, ref_op);

`ifdef PM_PARITY_EN
    dut.mem_q[2][3] = ~dut.mem_q[2][3];
    ps_pm_cslt = 1'b1; ps_pm_add = 16'd2;
    tick();
    ps_pm_cslt = 1'b0;
    ref_op = '0;
    check("par_op", pm_ps_op, 32'd0);
    check("par_perr", 32'(pm_perr), 32'd1);
`else
    fetch(16'd2, 1'b0);
    check("no_par_perr", 32'(pm_perr), 32'd0);
`endif

    // Out-of-range fetch, sticky error, write attempt
    fetch(16'(DEPTH), 1'b0);
    fetch(16'd1, 1'b0);
    fetch(16'd1, 1'b1);
    fetch(16'd1, 1'b0);
    fetch(16'($urandom_range(DEPTH, 16'hFFFF)), 1'b0);

    // Reset in the middle of a reload; partial words persist
    start_load();
    send_word(spec_words[0], 1'b0);
    send_word(spec_words[1], 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_cnt", 32'(ld_cnt), 32'd0);
    check("midrst_ready", 32'(ld_ready), 32'd0);
    check("midrst_err", 32'(pm_err), 32'd0);
    tick();
    rst = 1'b1;
    start_load();
    send_word(32'hAAAA_0000, 1'b1);
    fetch(16'd0, 1'b0);
    fetch(16'd1, 1'b0);
    check("reload_a0", ref_mem[0], 32'hAAAA_0000);

    // Random short load with a restart partway through
    start_load();
    send_word($urandom(), 1'b0);
    send_word($urandom(), 1'b0);
    start_load();
    n = $urandom_range(5, 12);
    for (int unsigned i = 0; i < n; i++) send_word($urandom(), i == n - 1);
    for (int unsigned k = 0; k < 16; k++) fetch(16'($urandom_range(0, n + 1)), 1'b0);

    // Full-depth load without ld_last: completes and saturates
    start_load();
    for (int unsigned i = 0; i < DEPTH; i++) send_word($urandom(), 1'b0);
    ld_valid = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      ld_data = $urandom();
      tick();
      check("sat_cnt", 32'(ld_cnt), 32'(DEPTH));
      check("sat_done", 32'(ld_done), 32'd0);
    end
    ld_valid = 1'b0;
    for (int unsigned k = 0; k < 16; k++) fetch(16'($urandom_range(0, DEPTH - 1)), 1'b0);
    fetch(16'(DEPTH - 1), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, required finish within bound");
    $fatal(1, "timeout");
  end

endmodule
